// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bus of the round-robin mux arbiter: requests and words in,
// grant/select and the registered selected word out.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 8
) ();
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_in;
  logic [3:0]         grant;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   data_out;
  logic               valid_out;
  logic               busy;

  modport master (
    output req, data_in,
    input  grant, sel, data_out, valid_out, busy
  );

  modport slave (
    input  req, data_in,
    output grant, sel, data_out, valid_out, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a 4:1 select datapath, with a per-owner burst
// limit that only bites while another requester is waiting.
module rr_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  rr_mux_arbiter_if.slave  bus
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n, sel_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       grant_n, others;
  logic [WIDTH-1:0] words [4];
  logic             idle_found, rr_found;
  logic [1:0]       idle_pick, rr_pick;

  // {found, index} of the first set bit of r, scanning start, start+1, ... mod 4
  function automatic logic [2:0] first_set(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Excluding the owner's bit lets a full 4-position scan from owner+1 cover
  // exactly the other three requesters.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) words[i] = bus.data_in[i*WIDTH +: WIDTH];
    others                  = bus.req & ~bus.grant;
    {idle_found, idle_pick} = first_set(bus.req, ptr);
    {rr_found, rr_pick}     = first_set(others, bus.sel + 2'd1);
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = bus.grant;
    sel_n   = bus.sel;
    unique case (state)
      IDLE: begin
        if (idle_found) begin
          grant_n = 4'b0001 << idle_pick;
          sel_n   = idle_pick;
          cnt_n   = CNT_ONE;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.req[bus.sel] && (cnt < CNT_MAX || others == '0)) begin
          if (cnt < CNT_MAX) cnt_n = cnt + CNT_ONE;
        end else begin
          ptr_n = bus.sel + 2'd1;
          if (rr_found) begin
            grant_n = 4'b0001 << rr_pick;
            sel_n   = rr_pick;
            cnt_n   = CNT_ONE;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      bus.grant     <= '0;
      bus.sel       <= '0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      bus.grant <= grant_n;
      bus.sel   <= sel_n;
      // Capture follows the grant already on the bus, hence one cycle behind it
      if (bus.grant != '0) begin
        bus.data_out  <= words[bus.sel];
        bus.valid_out <= 1'b1;
      end else begin
        bus.valid_out <= 1'b0;
      end
    end
  end

  assign bus.busy = (state == GRANT);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic against
// an integer-level model of the round-robin and burst-limit rules.
module tb_rr_mux_arbiter;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  rr_mux_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: owner index or -1 when idle, run length, priority pointer
  int               m_owner = -1;
  int               m_ptr   = 0;
  int               m_cnt   = 0;
  int               m_sel   = 0;
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_valid = 1'b0;

  function automatic logic [3:0] exp_grant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_step();
    int others;
    int pick;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_data = '0; m_valid = 1'b0;
      return;
    end
    if (m_owner >= 0) begin
      m_data  = WIDTH'(bus.data_in >> (m_owner * WIDTH));
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    pick = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++)
        if (pick < 0 && bus.req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      if (pick >= 0) begin m_owner = pick; m_sel = pick; m_cnt = 1; end
    end else begin
      others = 0;
      for (int k = 0; k < 4; k++) if (k != m_owner && bus.req[k]) others++;
      if (bus.req[m_owner] && (m_cnt < HOLD_MAX || others == 0)) begin
        m_cnt = (m_cnt + 1 > HOLD_MAX) ? HOLD_MAX : m_cnt + 1;
      end else begin
        m_ptr = (m_owner + 1) % 4;
        for (int k = 1; k < 4; k++)
          if (pick < 0 && bus.req[(m_owner + k) % 4]) pick = (m_owner + k) % 4;
        if (pick >= 0) begin m_owner = pick; m_sel = pick; m_cnt = 1; end
        else m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 4'b1111; bus.data_in = 32'h44332211;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({bus.grant, bus.sel, bus.valid_out, bus.busy, bus.data_out} !== 16'h0) begin
        errors++;
        $display("FAIL reset: grant=%b sel=%0d valid=%b busy=%b data=%h, required all zero",
                 bus.grant, bus.sel, bus.valid_out, bus.busy, bus.data_out);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: grant=%b sel=%0d, required 0001 sel 0", bus.grant, bus.sel);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100; bus.data_in = 32'h44A52211;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_grant c%0d: grant=%b sel=%0d busy=%b, required 0100 sel 2 busy 1",
                 c, bus.grant, bus.sel, bus.busy);
      end
      checks++;
      if (bus.valid_out !== (c >= 2) || (c >= 2 && bus.data_out !== 8'hA5)) begin
        errors++;
        $display("FAIL single_data c%0d: valid=%b data=%h, required valid %0d data a5",
                 c, bus.valid_out, bus.data_out, (c >= 2));
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    bus.req = 4'b1111; bus.data_in = 32'hDDCCBBAA;
    for (int c = 1; c <= 17; c++) begin
      tick();
      exp = 4'b0001 << (((c - 1) / HOLD_MAX) % 4);
      checks++;
      if (bus.grant !== exp || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL fairness c%0d: grant=%b busy=%b, required %b busy 1", c, bus.grant, bus.busy, exp);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] seq [9];
    seq = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    bus.data_in = 32'h44332211;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       bus.req = 4'b0010;
        1:       bus.req = 4'b1010;
        2:       bus.req = 4'b1000;
        3, 4, 5: bus.req = 4'b1010;
        6:       bus.req = 4'b0010;
        default: bus.req = 4'b0000;
      endcase
      tick();
      checks++;
      if (bus.grant !== seq[c]) begin
        errors++;
        $display("FAIL early_release c%0d: grant=%b, required %b", c, bus.grant, seq[c]);
      end
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 8'h22) begin
      errors++;
      $display("FAIL early_release_tail: valid=%b busy=%b data=%h, required 0 0 22",
               bus.valid_out, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0100; bus.data_in = 32'h44332211;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.grant !== 4'b0000 || bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_burst_reset: grant=%b valid=%b busy=%b data=%h, required all zero",
               bus.grant, bus.valid_out, bus.busy, bus.data_out);
    end
    rst = 1'b0; bus.req = 4'b0110;
    tick();
    checks++;
    if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin
      errors++;
      $display("FAIL mid_burst_regrant: grant=%b sel=%0d, required 0010 sel 1", bus.grant, bus.sel);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000; bus.data_in = 32'h44332211;
    tick();
    bus.req = 4'b0001;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'd0 || bus.data_out !== 8'h44) begin
      errors++;
      $display("FAIL wrap: grant=%b sel=%0d data=%h, required 0001 sel 0 data 44",
               bus.grant, bus.sel, bus.data_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.data_in = (4*WIDTH)'($urandom());
      tick();
      got = {bus.grant, bus.sel, bus.valid_out, bus.busy, bus.data_out};
      exp = {exp_grant(), 2'(m_sel), m_valid, (m_owner >= 0), m_data};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random c%0d: grant/sel/valid/busy/data=%h, required %h", c, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.data_in = '0;
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_reset_mid_burst();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
